// File: rtl/hash_round_ctrl.sv
// Sequencer for the 4-byte hash round. A last block accepted at edge T shows digest_valid at T+N_ROUNDS+2.
// msg_ready is high only in IDLE and the digest is held until taken. Define HASH_ROUND_CTRL_PERF_EN to add perf_cycles.
module hash_round_ctrl #(
  parameter int N_ROUNDS = 8,
  parameter int CNT_W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0][7:0] iv,
  input  logic            msg_valid,
  output logic            msg_ready,
  input  logic [3:0][7:0] msg_data,
  input  logic            msg_last,
  output logic [2:0]      round_state,
  output logic [3:0][7:0] round_h_in,
  output logic [3:0][7:0] round_iv,
  input  logic [3:0][7:0] round_h_out,
  output logic            digest_valid,
  input  logic            digest_ready,
  output logic [3:0][7:0] digest,
  output logic            busy
`ifdef HASH_ROUND_CTRL_PERF_EN
  ,
  output logic [15:0]     perf_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'b000,
    S_CALC_SA    = 3'b001,
    S_CALC_ROUND = 3'b010,
    S_CALC_FINAL = 3'b011,
    S_DONE       = 3'b100
  } state_t;

  state_t          state_q, state_d;
  logic [3:0][7:0] h_q, iv_q, msg_q, digest_q;
  logic            last_q, first_q;
  logic [CNT_W-1:0] cnt_q;
  logic            msg_xfer, last_rnd;

  // Ready is masked while reset is asserted so no block can slip in during reset.
  assign msg_ready    = (state_q == S_IDLE) && rst_n;
  assign msg_xfer     = msg_valid && msg_ready;
  assign last_rnd     = (cnt_q == CNT_W'(N_ROUNDS - 1));
  assign round_state  = state_q;
  assign round_iv     = iv_q;
  assign digest       = digest_q;
  assign digest_valid = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    round_h_in = '0;
    case (state_q)
      S_IDLE: begin
        if (msg_xfer) state_d = S_CALC_SA;
      end
      S_CALC_SA: begin
        round_h_in = msg_q ^ h_q;
        state_d    = S_CALC_ROUND;
      end
      S_CALC_ROUND: begin
        round_h_in = h_q;
        if (last_rnd) state_d = last_q ? S_CALC_FINAL : S_IDLE;
      end
      S_CALC_FINAL: begin
        round_h_in = h_q;
        state_d    = S_DONE;
      end
      S_DONE: begin
        if (digest_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q      <= '0;
      iv_q     <= '0;
      msg_q    <= '0;
      digest_q <= '0;
      last_q   <= 1'b0;
      first_q  <= 1'b1;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (msg_xfer) begin
            msg_q  <= msg_data;
            last_q <= msg_last;
            // IV is sampled only at the start of a message; later blocks chain from H.
            if (first_q) begin
              iv_q <= iv;
              h_q  <= iv;
            end
          end
        end
        S_CALC_SA: begin
          h_q   <= round_h_out;
          cnt_q <= '0;
        end
        S_CALC_ROUND: begin
          h_q   <= round_h_out;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_rnd && !last_q) first_q <= 1'b0;
        end
        S_CALC_FINAL: begin
          h_q      <= round_h_out;
          digest_q <= round_h_out;
        end
        S_DONE: begin
          if (digest_ready) begin
            first_q <= 1'b1;
            h_q     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HASH_ROUND_CTRL_PERF_EN
  logic [15:0] perf_q;

  // Counts SA/ROUND/FINAL cycles of a message; frozen in DONE and idle gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (msg_xfer && first_q) begin
      perf_q <= '0;
    end else if (busy && (state_q != S_DONE) && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_hash_round_ctrl.sv
// Directed bench for hash_round_ctrl (N_ROUNDS=8 and N_ROUNDS=1) with a toy round function.
module tb_hash_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [3:0][7:0] iv, msg_data, round_h_in, round_iv, round_h_out, digest;
  logic            msg_valid, msg_ready, msg_last, digest_valid, digest_ready, busy;
  logic [2:0]      round_state;

  logic [3:0][7:0] b_iv, b_msg_data, b_round_h_in, b_round_iv, b_round_h_out, b_digest;
  logic            b_msg_valid, b_msg_ready, b_msg_last, b_digest_valid, b_digest_ready, b_busy;
  logic [2:0]      b_round_state;

`ifdef HASH_ROUND_CTRL_PERF_EN
  logic [15:0] perf_cycles, b_perf_cycles;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Toy round: state- and IV-dependent so a wrong code or IV shows in the digest.
  function automatic logic [31:0] rf(input logic [31:0] h, input logic [31:0] v, input logic [2:0] st);
    return ({h[30:0], h[31]} + v) ^ {29'd0, st};
  endfunction

  function automatic logic [31:0] after_blk(input logic [31:0] h, input logic [31:0] m,
                                            input logic [31:0] v, input int n);
    logic [31:0] x;
    x = rf(m ^ h, v, 3'd1);
    for (int i = 0; i < n; i++) x = rf(x, v, 3'd2);
    return x;
  endfunction

  assign round_h_out   = rf(round_h_in, round_iv, round_state);
  assign b_round_h_out = rf(b_round_h_in, b_round_iv, b_round_state);

  hash_round_ctrl #(.N_ROUNDS(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .iv(iv),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data), .msg_last(msg_last),
    .round_state(round_state), .round_h_in(round_h_in), .round_iv(round_iv), .round_h_out(round_h_out),
    .digest_valid(digest_valid), .digest_ready(digest_ready), .digest(digest), .busy(busy)
`ifdef HASH_ROUND_CTRL_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  hash_round_ctrl #(.N_ROUNDS(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .iv(b_iv),
    .msg_valid(b_msg_valid), .msg_ready(b_msg_ready), .msg_data(b_msg_data), .msg_last(b_msg_last),
    .round_state(b_round_state), .round_h_in(b_round_h_in), .round_iv(b_round_iv), .round_h_out(b_round_h_out),
    .digest_valid(b_digest_valid), .digest_ready(b_digest_ready), .digest(b_digest), .busy(b_busy)
`ifdef HASH_ROUND_CTRL_PERF_EN
    , .perf_cycles(b_perf_cycles)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a block and returns one step after the accepting edge (state CALC_SA visible).
  task automatic send(input logic [31:0] d, input logic l);
    int g;
    g = 0;
    msg_data  = d;
    msg_last  = l;
    msg_valid = 1'b1;
    while (!msg_ready && g < 100) begin
      step();
      g++;
    end
    if (!msg_ready) check("send_rdy", 32'(msg_ready), 32'd1);
    step();
    msg_valid = 1'b0;
  endtask

  // Counts edges from the accepting edge until digest_valid.
  task automatic wait_digest(input string tag, input int exp_edges);
    int e;
    e = 0;
    while (!digest_valid && e < 60) begin
      step();
      e++;
    end
    check(tag, 32'(e), 32'(exp_edges));
  endtask

  logic [31:0] g1, h1, g2, gb, ga, gbb;
  int          cnt;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; iv = '0; msg_valid = 1'b0; msg_data = '0; msg_last = 1'b0; digest_ready = 1'b0;
    b_iv = '0; b_msg_valid = 1'b0; b_msg_data = '0; b_msg_last = 1'b0; b_digest_ready = 1'b0;
    #3;
    check("rst_state",   32'(round_state), 32'd0);
    check("rst_rdy",     32'(msg_ready), 32'd0);
    check("rst_dvld",    32'(digest_valid), 32'd0);
    check("rst_digest",  digest, 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_hin",     round_h_in, 32'd0);
    check("rst_iv",      round_iv, 32'd0);
`ifdef HASH_ROUND_CTRL_PERF_EN
    check("rst_perf",    32'(perf_cycles), 32'd0);
`endif
    #4 rst_n = 1'b1;
    step();
    check("rdy_after_rst", 32'(msg_ready), 32'd1);

    // Single block, N_ROUNDS=8, then digest backpressure.
    iv = 32'h01020304;
    g1 = rf(after_blk(32'h01020304, 32'hA5A5A5A5, 32'h01020304, 8), 32'h01020304, 3'd3);
    send(32'hA5A5A5A5, 1'b1);
    check("t1_sa_state", 32'(round_state), 32'd1);
    check("t1_sa_hin",   round_h_in, 32'hA4A7A6A1);
    check("t1_sa_rdy",   32'(msg_ready), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("t1_round%0d", i), 32'(round_state), 32'd2);
    end
    step();
    check("t1_final", 32'(round_state), 32'd3);
    step();
    check("t1_done",   32'(round_state), 32'd4);
    check("t1_dvld",   32'(digest_valid), 32'd1);
    check("t1_digest", digest, g1);
`ifdef HASH_ROUND_CTRL_PERF_EN
    check("t1_perf", 32'(perf_cycles), 32'd10);
`endif
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("bp_dvld%0d", i), 32'(digest_valid), 32'd1);
      check($sformatf("bp_dig%0d", i),  digest, g1);
    end
    step();
    check("bp_dvld6", 32'(digest_valid), 32'd1);
`ifdef HASH_ROUND_CTRL_PERF_EN
    check("bp_perf_frozen", 32'(perf_cycles), 32'd10);
`endif
    digest_ready = 1'b1;
    step();
    digest_ready = 1'b0;
    check("bp_rdy_after", 32'(msg_ready), 32'd1);
    check("bp_dvld_off",  32'(digest_valid), 32'd0);

    // Two-block message, valid held high, iv changed between blocks.
    h1 = after_blk(32'h01020304, 32'h11223344, 32'h01020304, 8);
    g2 = rf(after_blk(h1, 32'h55667788, 32'h01020304, 8), 32'h01020304, 3'd3);
    msg_data = 32'h11223344; msg_last = 1'b0; msg_valid = 1'b1;
    step();
    check("t2_acc1", 32'(round_state), 32'd1);
    msg_data = 32'h55667788; msg_last = 1'b1; iv = 32'hFFFFFFFF;
    digest_ready = 1'b1;
    cnt = 0;
    while (!msg_ready && cnt < 30) begin
      cnt++;
      step();
    end
    check("t2_rdy_low_cycles", 32'(cnt), 32'd9);
    check("t2_gap_busy", 32'(busy), 32'd0);
    step();
    msg_valid = 1'b0;
    digest_ready = 1'b0;
    check("t2_sa2_hin", round_h_in, 32'h55667788 ^ h1);
    check("t2_iv_kept", round_iv, 32'h01020304);
    wait_digest("t2_latency", 10);
    check("t2_digest", digest, g2);
`ifdef HASH_ROUND_CTRL_PERF_EN
    check("t2_perf", 32'(perf_cycles), 32'd19);
`endif
    digest_ready = 1'b1;
    step();
    digest_ready = 1'b0;
    check("t2_rdy_after", 32'(msg_ready), 32'd1);

    // Reset during CALC_ROUND with cnt=3, then a clean rerun.
    iv = 32'h01020304;
    send(32'hA5A5A5A5, 1'b1);
    repeat (4) step();
    check("t3_in_round", 32'(round_state), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("t3_rst_state",  32'(round_state), 32'd0);
    check("t3_rst_busy",   32'(busy), 32'd0);
    check("t3_rst_rdy",    32'(msg_ready), 32'd0);
    check("t3_rst_dvld",   32'(digest_valid), 32'd0);
    check("t3_rst_digest", digest, 32'd0);
    check("t3_rst_iv",     round_iv, 32'd0);
    #1 rst_n = 1'b1;
    step();
    send(32'hA5A5A5A5, 1'b1);
    wait_digest("t3_latency", 10);
    check("t3_digest", digest, g1);
    digest_ready = 1'b1;
    step();
    digest_ready = 1'b0;

    // N_ROUNDS=1 instance.
    gb = rf(after_blk(32'h01020304, 32'hA5A5A5A5, 32'h01020304, 1), 32'h01020304, 3'd3);
    b_iv = 32'h01020304; b_msg_data = 32'hA5A5A5A5; b_msg_last = 1'b1; b_msg_valid = 1'b1;
    check("n1_rdy", 32'(b_msg_ready), 32'd1);
    step();
    b_msg_valid = 1'b0;
    check("n1_sa", 32'(b_round_state), 32'd1);
    step();
    check("n1_round", 32'(b_round_state), 32'd2);
    step();
    check("n1_final", 32'(b_round_state), 32'd3);
    step();
    check("n1_done",   32'(b_round_state), 32'd4);
    check("n1_dvld",   32'(b_digest_valid), 32'd1);
    check("n1_digest", b_digest, gb);
`ifdef HASH_ROUND_CTRL_PERF_EN
    check("n1_perf", 32'(b_perf_cycles), 32'd3);
`endif
    b_digest_ready = 1'b1;
    step();
    b_digest_ready = 1'b0;
    check("n1_dvld_off", 32'(b_digest_valid), 32'd0);

    // digest_ready held high: one-cycle digest_valid, back-to-back messages.
    ga  = rf(after_blk(32'h01020304, 32'hDEADBEEF, 32'h01020304, 8), 32'h01020304, 3'd3);
    gbb = rf(after_blk(32'h01020304, 32'h0BADF00D, 32'h01020304, 8), 32'h01020304, 3'd3);
    digest_ready = 1'b1;
    send(32'hDEADBEEF, 1'b1);
    wait_digest("t5a_latency", 10);
    check("t5a_digest", digest, ga);
    step();
    check("t5a_dvld_1cyc", 32'(digest_valid), 32'd0);
    check("t5a_rdy",       32'(msg_ready), 32'd1);
    send(32'h0BADF00D, 1'b1);
    check("t5b_hin", round_h_in, 32'h0BADF00D ^ 32'h01020304);
    wait_digest("t5b_latency", 10);
    check("t5b_digest", digest, gbb);
    step();
    check("t5b_dvld_1cyc", 32'(digest_valid), 32'd0);
    digest_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hash_round_ctrl.md
Name: hash_round_ctrl

Overview:
- Sequencer for the 4-byte hash round datapath.
- Accepts 32-bit message blocks over a valid/ready handshake and holds the chaining state H (4x8 bits).
- Drives the round's state select, H_in and IV each cycle, captures H_out, and presents the final digest over a valid/ready handshake.
- Sits between the message source and the combinational round.

Parameters:
- N_ROUNDS, 8, number of CALC_ROUND cycles per block; legal range 1..255.
- CNT_W, 8, width of the round counter; must satisfy 2^CNT_W > N_ROUNDS.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- iv  in  4x8  initialisation vector; sampled on the first accepted block of a message.
- msg_valid  in  1  message block valid.
- msg_ready  out  1  controller can accept a block.
- msg_data  in  4x8  message block, byte 0 first.
- msg_last  in  1  block is the final block of the message; qualified by msg_valid.
- round_state  out  3  state code to the round: IDLE=000, CALC_SA=001, CALC_ROUND=010, CALC_FINAL=011, DONE=100.
- round_h_in  out  4x8  H_in to the round.
- round_iv  out  4x8  IV to the round (latched copy).
- round_h_out  in  4x8  H_out from the round (combinational, same cycle).
- digest_valid  out  1  digest available.
- digest_ready  in  1  consumer accepts the digest.
- digest  out  4x8  final hash value.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst_n low): state=IDLE, H=0, iv_q=0, round counter=0, first-block flag=1, last flag=0; msg_ready=0 during reset; digest_valid=0, digest=0, busy=0.
- Handshakes: transfer occurs when valid and ready are both high on a rising edge. msg_ready is high only in IDLE. digest_valid is high only in DONE.

State machine:
- IDLE: round_state=000, round_h_in=0.
  - On a msg_valid&&msg_ready transfer: latch msg_data and msg_last.
  - If first-block flag is set: iv_q<=iv and H<=iv.
  - Go to CALC_SA.
- CALC_SA, 1 cycle: round_state=001, round_h_in = msg_q XOR H. Capture H<=round_h_out; cnt<=0; go to CALC_ROUND.
- CALC_ROUND, N_ROUNDS cycles: round_state=010, round_h_in=H. Capture H<=round_h_out; cnt<=cnt+1.
  - When cnt==N_ROUNDS-1 and last_q=1: go to CALC_FINAL.
  - When cnt==N_ROUNDS-1 and last_q=0: go to IDLE with first-block flag cleared.
- CALC_FINAL, 1 cycle: round_state=011, round_h_in=H. Capture digest<=round_h_out and H<=round_h_out; go to DONE.
- DONE: round_state=100, digest_valid=1, digest held stable.
  - On digest_ready: go to IDLE, set first-block flag, clear H to 0.

Timing and boundary rules:
- Latency: a last block accepted at edge T gives digest_valid at edge T+N_ROUNDS+2. A non-last block returns msg_ready at edge T+N_ROUNDS+1.
- N_ROUNDS=1: CALC_ROUND lasts exactly one cycle.
- msg_valid while busy: ignored, no transfer; msg_data may change freely.
- digest_ready held high on entry to DONE: digest_valid is high for exactly 1 cycle.
- digest_ready while not in DONE: ignored.
- iv changing mid-message: no effect; iv_q is used.
- Reset mid-operation: immediate return to IDLE with all reset values; no partial digest is emitted.
- round_iv = iv_q in all states.
- Unreachable state encodings: recover to IDLE.

Optional Feature:
- Macro: HASH_ROUND_CTRL_PERF_EN.
- Enabled:
  - Adds output perf_cycles (16 bits): counts busy cycles from the first block accepted after entering IDLE with the first-block flag set, up to entry to DONE.
  - Frozen in DONE; cleared when the next message's first block is accepted; saturates at 0xFFFF; reset value 0.
- Disabled: port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset then single-block message, N_ROUNDS=8, iv=0x01020304, msg_data=0xA5A5A5A5, msg_last=1:
  - round_state sequence 001, then 010 x8, then 011, then 100.
  - First round_h_in = 0xA4A7A6A1.
  - digest_valid rises 10 edges after acceptance; digest equals the golden model; perf_cycles=10 when enabled.
- Two-block message, second msg_valid held high from cycle 0:
  - msg_ready low for 9 cycles, then second block accepted.
  - iv not re-sampled (iv changed to 0xFFFFFFFF between blocks has no effect).
  - Second CALC_SA round_h_in = msg2 XOR H after block 1.
- Digest backpressure: digest_ready low for 5 cycles.
  - digest_valid and digest stable for 5 cycles.
  - Accepted on the 6th; msg_ready high on the next cycle.
- rst_n pulsed low at CALC_ROUND cnt=3:
  - Outputs go to reset values asynchronously.
  - Next message produces the same digest as a clean run.
- N_ROUNDS=1, single block: round_state sequence 001, 010, 011, 100; digest_valid 3 edges after acceptance.
- digest_ready held high throughout: digest_valid high for exactly 1 cycle per message; back-to-back messages are accepted without loss.
